// File: rtl/pll_freq_ctrl_if.sv
// +----------------------------------------------------------------------+
// | Module : pll_freq_ctrl_if                                            |
// | Brief  : Control/measurement bundle between the loop and its user    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface pll_freq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic [CNT_W-1:0] target_i;
  logic             fb_clk_i;
  logic             freq_incr_o;
  logic             freq_decr_o;
  logic             stable_cfg_o;
  logic [CNT_W-1:0] meas_count_o;
  logic             meas_valid_o;

  modport master (
    output en_i, target_i, fb_clk_i,
    input  freq_incr_o, freq_decr_o, stable_cfg_o, meas_count_o, meas_valid_o
  );

  modport slave (
    input  en_i, target_i, fb_clk_i,
    output freq_incr_o, freq_decr_o, stable_cfg_o, meas_count_o, meas_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/pll_freq_ctrl.sv
// +----------------------------------------------------------------------+
// | Module : pll_freq_ctrl                                               |
// | Brief  : Windowed feedback-edge counter driving VCO correction pulses |
// |          and a settled flag. Option macro: PLL_FREQ_CTRL_HYST_EN      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pll_freq_ctrl #(
  parameter int CNT_W        = 16,
  parameter int WIN_CYCLES   = 1024,
  parameter int TOL          = 1,
  parameter int MAX_PULSE    = 8,
  parameter int LOCK_WINDOWS = 4
) (
  input  wire logic        clk_i,
  input  wire logic        arst_i,
  pll_freq_ctrl_if.slave   bus
);

  localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int PUL_W = $clog2(MAX_PULSE + 1);
  localparam int LCK_W = $clog2(LOCK_WINDOWS + 1);
  localparam int ERR_W = CNT_W + 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [ERR_W-1:0] TOL_N    = ERR_W'(TOL);
  localparam logic [ERR_W-1:0] MAX_N    = ERR_W'(MAX_PULSE);
  localparam logic [LCK_W-1:0] LOCK_N   = LCK_W'(LOCK_WINDOWS);
`ifdef PLL_FREQ_CTRL_HYST_EN
  localparam logic [ERR_W-1:0] TOL_H    = ERR_W'(2 * TOL);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    ADJUST  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             fb_meta_q, fb_meta_d;
  logic             fb_sync_q, fb_sync_d;
  logic             fb_prev_q, fb_prev_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edges_q, edges_d;
  logic [PUL_W-1:0] left_q, left_d;
  logic [LCK_W-1:0] lock_q, lock_d;
  logic             incr_q, incr_d;
  logic             decr_q, decr_d;
  logic             stable_q, stable_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] meas_q, meas_d;

  logic             fb_rise;
  logic [CNT_W-1:0] count_fin;
  logic [ERR_W-1:0] err;
  logic [ERR_W-1:0] err_mag;
  logic [ERR_W-1:0] tol_eff;
  logic             in_tol;
  logic [PUL_W-1:0] pulse_len;

  always_comb begin
    fb_meta_d = bus.fb_clk_i;
    fb_sync_d = fb_meta_q;
    fb_prev_d = fb_sync_q;
    fb_rise   = fb_sync_q & ~fb_prev_q;

    count_fin = (fb_rise && (edges_q != '1)) ? edges_q + CNT_W'(1) : edges_q;

    // two's-complement difference; MSB is the sign of target - count
    err     = {1'b0, bus.target_i} - {1'b0, count_fin};
    err_mag = err[ERR_W-1] ? (~err + ERR_W'(1)) : err;
`ifdef PLL_FREQ_CTRL_HYST_EN
    tol_eff = stable_q ? TOL_H : TOL_N;
`else
    tol_eff = TOL_N;
`endif
    in_tol    = (err_mag <= tol_eff);
    pulse_len = (err_mag > MAX_N) ? PUL_W'(MAX_PULSE) : err_mag[PUL_W-1:0];

    state_d  = state_q;
    win_d    = win_q;
    edges_d  = edges_q;
    left_d   = left_q;
    lock_d   = lock_q;
    incr_d   = incr_q;
    decr_d   = decr_q;
    stable_d = stable_q;
    valid_d  = 1'b0;
    meas_d   = meas_q;

    case (state_q)
      IDLE: begin
        incr_d   = 1'b0;
        decr_d   = 1'b0;
        stable_d = 1'b0;
        lock_d   = '0;
        win_d    = '0;
        edges_d  = '0;
        if (bus.en_i) state_d = MEASURE;
      end

      MEASURE: begin
        edges_d = count_fin;
        win_d   = win_q + WIN_W'(1);
        if (win_q == WIN_LAST) begin
          meas_d   = count_fin;
          valid_d  = 1'b1;
          lock_d   = !in_tol ? '0 : (lock_q == LOCK_N) ? lock_q : lock_q + LCK_W'(1);
          stable_d = (lock_d == LOCK_N);
          incr_d   = !in_tol && !err[ERR_W-1];
          decr_d   = !in_tol &&  err[ERR_W-1];
          // out of tolerance implies |err| >= 1, so pulse_len is never 0 here
          left_d   = in_tol ? '0 : pulse_len - PUL_W'(1);
          state_d  = ADJUST;
        end
      end

      ADJUST: begin
        if (left_q == '0) begin
          incr_d  = 1'b0;
          decr_d  = 1'b0;
          win_d   = '0;
          edges_d = '0;
          state_d = MEASURE;
        end else begin
          left_d = left_q - PUL_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // disabling overrides every state and cuts a pulse on the next edge
    if (!bus.en_i) begin
      state_d  = IDLE;
      incr_d   = 1'b0;
      decr_d   = 1'b0;
      stable_d = 1'b0;
      valid_d  = 1'b0;
      lock_d   = '0;
      meas_d   = meas_q;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      fb_meta_q <= 1'b0;
      fb_sync_q <= 1'b0;
      fb_prev_q <= 1'b0;
      win_q     <= '0;
      edges_q   <= '0;
      left_q    <= '0;
      lock_q    <= '0;
      incr_q    <= 1'b0;
      decr_q    <= 1'b0;
      stable_q  <= 1'b0;
      valid_q   <= 1'b0;
      meas_q    <= '0;
    end else begin
      state_q   <= state_d;
      fb_meta_q <= fb_meta_d;
      fb_sync_q <= fb_sync_d;
      fb_prev_q <= fb_prev_d;
      win_q     <= win_d;
      edges_q   <= edges_d;
      left_q    <= left_d;
      lock_q    <= lock_d;
      incr_q    <= incr_d;
      decr_q    <= decr_d;
      stable_q  <= stable_d;
      valid_q   <= valid_d;
      meas_q    <= meas_d;
    end
  end

  assign bus.freq_incr_o  = incr_q;
  assign bus.freq_decr_o  = decr_q;
  assign bus.stable_cfg_o = stable_q;
  assign bus.meas_count_o = meas_q;
  assign bus.meas_valid_o = valid_q;

endmodule

`default_nettype wire
